pipeline_skid_reg: RTL

Parametrised, elastic pipeline-stage register: the handshaked successor of the plain single-cycle stage register. It carries an N-bit payload between two pipeline stages with valid/ready flow control, a two-entry skid buffer for full throughput under backpressure, and a synchronous flush for branch/exception squashing. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_skid_reg.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipeline_skid_reg.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
// Optional stall counter output enabled by defining PIPEREG_STALL_CNT_EN.
//
// state | meaning
// EMPTY | no beat held, out_valid low
// ONE   | main holds the head beat
// TWO   | main holds head, skid holds the next beat; upstream stalled
module pipeline_skid_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
`ifdef PIPEREG_STALL_CNT_EN
  output logic [1:0]   occupancy,
  output logic [15:0]  stall_cnt
`else
  output logic [1:0]   occupancy
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;
  logic         push;
  logic         pop;

  // Handshake outputs come from registered state only, so in_ready never sees out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out       = main_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rest) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q <= in;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in;
          end else if (push) begin
            skid_q <= in;
            state  <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPEREG_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts every backpressured cycle, flush included; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rest) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
